// File: rtl/vitals_frame_tx_if.sv
// rtl/vitals_frame_tx_if.sv - sample capture and word-stream handshake bundle for vitals_frame_tx
// The slave modport is the transmitter's view; master is the source/sink environment.
interface vitals_frame_tx_if #(
  parameter int WIDTH = 10
);
  logic [WIDTH-1:0] age;
  logic [WIDTH-1:0] bloodP;
  logic [WIDTH-1:0] breathR;
  logic [WIDTH-1:0] heartB;
  logic             sample_valid;
  logic             sample_ready;
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             tx_is_age;
  logic             tx_last;

  modport master (
    output age, bloodP, breathR, heartB, sample_valid, tx_ready,
    input  sample_ready, tx_data, tx_valid, tx_is_age, tx_last
  );

  modport slave (
    input  age, bloodP, breathR, heartB, sample_valid, tx_ready,
    output sample_ready, tx_data, tx_valid, tx_is_age, tx_last
  );
endinterface

// File: rtl/vitals_frame_tx.sv
// rtl/vitals_frame_tx.sv - serializes one vitals set into age/bloodP/breathR/heartB words
// Optional checksum word after heartB when VITALS_CHECKSUM_EN is defined.
module vitals_frame_tx #(
  parameter int WIDTH       = 10,
  parameter int FRAME_CNT_W = 16,
  parameter int AGE_PERIOD  = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  vitals_frame_tx_if.slave       frame_if,
  output logic [FRAME_CNT_W-1:0] frame_count_o
);

  localparam int PCW = 16;
  localparam logic [PCW-1:0] PERIOD_LAST = (AGE_PERIOD > 0) ? PCW'(AGE_PERIOD - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AGE  = 3'd1,
    S_BP   = 3'd2,
    S_BR   = 3'd3,
`ifdef VITALS_CHECKSUM_EN
    S_HB   = 3'd4,
    S_CHK  = 3'd5
`else
    S_HB   = 3'd4
`endif
  } state_t;

  state_t state_q, state_d;

  logic                   init_q, init_d;
  logic [WIDTH-1:0]       age_q, age_d;
  logic [WIDTH-1:0]       bp_q, bp_d;
  logic [WIDTH-1:0]       br_q, br_d;
  logic [WIDTH-1:0]       hb_q, hb_d;
  logic                   has_age_q, has_age_d;
  logic                   pending_q, pending_d;
  logic [WIDTH-1:0]       last_age_q, last_age_d;
  logic [PCW-1:0]         period_q, period_d;
  logic [FRAME_CNT_W-1:0] count_q, count_d;

  logic             capture;
  logic             need_age;
  logic             period_hit;
  logic             xfer;
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_is_age;
  logic             tx_last;
  logic             sample_ready;
`ifdef VITALS_CHECKSUM_EN
  logic [WIDTH-1:0] checksum;

  assign checksum = bp_q + br_q + hb_q + (has_age_q ? age_q : '0);
`endif

  // init_q keeps sample_ready low until the first clock after reset release
  assign capture    = (state_q == S_IDLE) && init_q && frame_if.sample_valid;
  assign period_hit = (AGE_PERIOD > 0) && (period_q == PERIOD_LAST);
  assign need_age   = pending_q || (frame_if.age != last_age_q) || period_hit;
  assign xfer       = tx_valid && frame_if.tx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (capture) state_d = need_age ? S_AGE : S_BP;
      S_AGE:  if (xfer) state_d = S_BP;
      S_BP:   if (xfer) state_d = S_BR;
      S_BR:   if (xfer) state_d = S_HB;
`ifdef VITALS_CHECKSUM_EN
      S_HB:   if (xfer) state_d = S_CHK;
      S_CHK:  if (xfer) state_d = S_IDLE;
`else
      S_HB:   if (xfer) state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_data      = '0;
    tx_valid     = 1'b0;
    tx_is_age    = 1'b0;
    tx_last      = 1'b0;
    sample_ready = 1'b0;
    case (state_q)
      S_IDLE: sample_ready = init_q;
      S_AGE: begin
        tx_valid  = 1'b1;
        tx_data   = age_q;
        tx_is_age = 1'b1;
      end
      S_BP: begin
        tx_valid = 1'b1;
        tx_data  = bp_q;
      end
      S_BR: begin
        tx_valid = 1'b1;
        tx_data  = br_q;
      end
      S_HB: begin
        tx_valid = 1'b1;
        tx_data  = hb_q;
`ifndef VITALS_CHECKSUM_EN
        tx_last  = 1'b1;
`endif
      end
`ifdef VITALS_CHECKSUM_EN
      S_CHK: begin
        tx_valid = 1'b1;
        tx_data  = checksum;
        tx_last  = 1'b1;
      end
`endif
      default: begin
        tx_valid = 1'b0;
      end
    endcase
  end

  always_comb begin
    init_d     = 1'b1;
    age_d      = age_q;
    bp_d       = bp_q;
    br_d       = br_q;
    hb_d       = hb_q;
    has_age_d  = has_age_q;
    pending_d  = pending_q;
    last_age_d = last_age_q;
    period_d   = period_q;
    count_d    = count_q;
    if (capture) begin
      age_d     = frame_if.age;
      bp_d      = frame_if.bloodP;
      br_d      = frame_if.breathR;
      hb_d      = frame_if.heartB;
      has_age_d = need_age;
    end
    if (xfer && tx_is_age) begin
      pending_d  = 1'b0;
      last_age_d = age_q;
      period_d   = '0;
    end
    // Only frames without an age header advance the forced-header period
    if (xfer && tx_last) begin
      count_d = count_q + FRAME_CNT_W'(1);
      if (!has_age_q) period_d = period_q + PCW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q     <= 1'b0;
      age_q      <= '0;
      bp_q       <= '0;
      br_q       <= '0;
      hb_q       <= '0;
      has_age_q  <= 1'b0;
      pending_q  <= 1'b1;
      last_age_q <= '0;
      period_q   <= '0;
      count_q    <= '0;
    end else begin
      init_q     <= init_d;
      age_q      <= age_d;
      bp_q       <= bp_d;
      br_q       <= br_d;
      hb_q       <= hb_d;
      has_age_q  <= has_age_d;
      pending_q  <= pending_d;
      last_age_q <= last_age_d;
      period_q   <= period_d;
      count_q    <= count_d;
    end
  end

  assign frame_if.tx_data      = tx_data;
  assign frame_if.tx_valid     = tx_valid;
  assign frame_if.tx_is_age    = tx_is_age;
  assign frame_if.tx_last      = tx_last;
  assign frame_if.sample_ready = sample_ready;
  assign frame_count_o         = count_q;

endmodule

// File: doc/vitals_frame_tx.md
Name: vitals_frame_tx

Overview:
- Transmit side of the vitals sample stream consumed by the lie detector.
- Accepts one parallel vitals set (blood pressure, breath rate, heart beat) plus subject age per handshake.
- Serializes the set onto a single WIDTH-bit word channel with valid/ready flow control, in the fixed word order the detector stream uses: age header, then bloodP, breathR, heartB.
- Sits between the sensor front-end / stimulus source and the detector input sequencer.

Parameters:
- WIDTH, 10: bit width of every sample word and of tx_data.
- FRAME_CNT_W, 16: width of the frames-sent counter.
- AGE_PERIOD, 0: 0 = send the age header only when required (see Behaviour); N>0 = also force the age header every N frames.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- age  in  WIDTH  subject age; sampled at capture.
- bloodP  in  WIDTH  blood pressure sample; sampled at capture.
- breathR  in  WIDTH  breath rate sample; sampled at capture.
- heartB  in  WIDTH  heart beat sample; sampled at capture.
- sample_valid  in  1  source offers a vitals set.
- sample_ready  out  1  block can capture a set this cycle.
- tx_data  out  WIDTH  current outgoing word.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  sink accepts the word.
- tx_is_age  out  1  the current word is the age header.
- tx_last  out  1  the current word is the final word of the frame.
- frame_count  out  FRAME_CNT_W  number of completed frames.

Behaviour:
- Reset (async assert, sync-to-clk deassert use):
  - All outputs are 0: tx_data, tx_valid, tx_is_age, tx_last, frame_count.
  - sample_ready = 0 while rst_n = 0. It goes to 1 on the first clock after rst_n deasserts.
  - State = IDLE. The age_pending flag is set to 1. The period counter is cleared.
- FSM states: IDLE, SEND_AGE, SEND_BP, SEND_BR, SEND_HB (plus SEND_CHK when the optional feature is compiled in).
- IDLE:
  - sample_ready = 1 and tx_valid = 0.
  - On sample_valid & sample_ready, capture all four inputs into holding registers.
  - Next state is SEND_AGE if any of these holds:
    - age_pending = 1;
    - the captured age differs from the last age sent;
    - AGE_PERIOD > 0 and the period counter has reached AGE_PERIOD-1.
  - Otherwise the next state is SEND_BP.
- Send states:
  - tx_valid = 1 and sample_ready = 0.
  - tx_data comes from the holding registers: age, bloodP, breathR, heartB.
  - tx_is_age = 1 only in SEND_AGE.
  - tx_last = 1 only in SEND_HB (only in SEND_CHK when the feature is compiled in).
  - A word transfers on tx_valid & tx_ready. The state advances on the same edge: AGE→BP→BR→HB→IDLE, with HB→CHK→IDLE when the feature is in.
  - While tx_ready = 0, tx_data, tx_is_age and tx_last hold stable. Input changes never affect an in-flight frame.
- Latency:
  - Capture edge → first word valid on the next cycle.
  - With tx_ready tied to 1, a frame occupies 3 or 4 cycles of tx_valid (+1 with the checksum).
  - Back-to-back frames have one IDLE cycle between them.
- On the age word transfer: clear age_pending and update last_age. The period counter resets on an age send and increments per completed frame without an age send.
- On the final-word transfer: frame_count increments by 1 and wraps modulo 2^FRAME_CNT_W.
- Any reset mid-frame aborts the frame:
  - the frame is not counted;
  - the next frame after reset always carries the age header.

Optional Feature:
- Macro: VITALS_CHECKSUM_EN.
- Defined:
  - Adds the SEND_CHK word after heartB.
  - tx_data in SEND_CHK = (bloodP + breathR + heartB) mod 2^WIDTH, plus age when the frame carries an age word, using the captured values.
  - tx_last moves to the CHK word.
- Undefined: no checksum logic and no SEND_CHK state; heartB is the last word.

Test Plan:
- Reset, then age=30, bloodP=120, breathR=16, heartB=72, sample_valid pulse, tx_ready=1 → words 30(is_age=1), 120, 16, 72(last=1) on consecutive cycles; frame_count=1.
- Second set with the same age=30, bloodP=118, breathR=15, heartB=70 → no age word; 118, 16→15, 70(last); frame_count=2. Then age=31 → age word 31 is sent first.
- tx_ready held 0 for 5 cycles during the breathR word while the inputs change → tx_data stays 16 and tx_valid stays 1; sequence resumes intact; sample_ready stays 0 throughout.
- AGE_PERIOD=3, constant age=25, 7 frames → age header on frames 1, 4, 7 only.
- rst_n pulled low during the SEND_BR word → outputs 0 immediately; frame_count unchanged at 0; next frame starts with the age word.
- With VITALS_CHECKSUM_EN, age=30, 120, 16, 72 → words 30, 120, 16, 72, 238 with tx_last on 238. With values 1000, 20, 10, no age → checksum 6 (1030 mod 1024).
